// File: rtl/ap_prof_pkg.sv
// ap_prof_pkg: shared record type, FSM states and saturating increment for the handshake profiler
package ap_prof_pkg;
  localparam int PROF_W = 32;
  typedef struct packed {
    logic [PROF_W-1:0] idx;
    logic [PROF_W-1:0] start_ts;
    logic [PROF_W-1:0] latency;
    logic [PROF_W-1:0] interval;
  } prof_rec_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} prof_state_e;
  function automatic logic [PROF_W-1:0] sat_inc(input logic [PROF_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/ap_prof_fifo.sv
// ap_prof_fifo: synchronous first-word-fall-through FIFO; push while full is taken only alongside a pop
module ap_prof_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty   = cnt == '0;
  assign full    = cnt == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty output reads as zero so stale entries never leak after reset
  assign dout    = empty ? '0 : mem[rd];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= nxt(wr);
      if (do_pop) rd <= nxt(rd);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clock) if (do_push) mem[wr] <= din;
endmodule

// File: rtl/ap_handshake_profiler.sv
// ap_handshake_profiler: pairs ap_ctrl_hs starts with completions, emits timestamped records and busy/stall counters
module ap_handshake_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W      = PROF_W,
  parameter int INFL_DEPTH = 4,
  parameter int REC_DEPTH  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_idx,
  output logic [CNT_W-1:0] rec_start_ts,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             overflow,
  output logic             inflight_err,
  output logic             done_flush
);
  prof_state_e state, state_nxt;
  logic [CNT_W-1:0] ts, last_ts, intv_now, start_ts, start_intv;
  logic [2*CNT_W-1:0] sq_out;
  logic have_prev, run, acc, cmp, bypass, sq_full, sq_empty, rf_full, rf_empty, rec_push, rf_pop;
  prof_rec_t rec_in, rec_out;
  assign run      = state == RUN;
  assign acc      = run && ap_start && ap_ready;
  assign cmp      = run && ap_done && ap_continue;
  // A completion on an empty queue can only pair with the start accepted in the same cycle
  assign bypass   = acc && cmp && sq_empty;
  assign intv_now = have_prev ? ts - last_ts : '0;
  assign {start_ts, start_intv} = bypass ? {ts, intv_now} : sq_out;
  assign rec_push = cmp && (acc || !sq_empty);
  assign rec_in   = '{idx: txn_count, start_ts: start_ts, latency: ts - start_ts, interval: start_intv};
  assign rec_valid = !rf_empty;
  assign rf_pop   = rec_valid && rec_ready;
  assign {rec_idx, rec_start_ts, rec_latency, rec_interval} = rec_out;
  assign done_flush = state == DONE;
  ap_prof_fifo #(.WIDTH(2*CNT_W), .DEPTH(INFL_DEPTH)) u_start_q (
    .clock(clock), .reset(reset), .push(acc && !bypass), .pop(cmp && !sq_empty),
    .din({ts, intv_now}), .dout(sq_out), .full(sq_full), .empty(sq_empty)
  );
  ap_prof_fifo #(.WIDTH($bits(prof_rec_t)), .DEPTH(REC_DEPTH)) u_rec_q (
    .clock(clock), .reset(reset), .push(rec_push), .pop(rf_pop),
    .din(rec_in), .dout(rec_out), .full(rf_full), .empty(rf_empty)
  );
  always_comb begin
    state_nxt = (run && finish) ? DRAIN : (state == DRAIN && rf_empty) ? DONE : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      ts           <= '0;
      last_ts      <= '0;
      have_prev    <= 1'b0;
      txn_count    <= '0;
      busy_cycles  <= '0;
      stall_cycles <= '0;
      overflow     <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (run) ts <= sat_inc(ts);
      if (run && (!sq_empty || ap_start)) busy_cycles <= sat_inc(busy_cycles);
      if (run && ap_done && !ap_continue) stall_cycles <= sat_inc(stall_cycles);
      if (acc) begin
        last_ts   <= ts;
        have_prev <= 1'b1;
      end
      if (rec_push) txn_count <= sat_inc(txn_count);
      if ((acc && sq_full && !cmp) || (cmp && sq_empty && !acc)) inflight_err <= 1'b1;
      if (rec_push && rf_full && !rf_pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ap_handshake_profiler.sv
// tb_ap_handshake_profiler: directed vectors with hand-computed expectations for the handshake profiler
module tb_ap_handshake_profiler;
  logic clock = 1'b0, reset = 1'b1, finish = 1'b0;
  logic ap_start = 1'b0, ap_ready = 1'b1, ap_done = 1'b0, ap_continue = 1'b1, rec_ready = 1'b0;
  logic rec_valid, overflow, inflight_err, done_flush;
  logic [31:0] rec_idx, rec_start_ts, rec_latency, rec_interval, txn_count, busy_cycles, stall_cycles;
  int n_cmp = 0, n_bad = 0;
  ap_handshake_profiler dut (
    .clock(clock), .reset(reset), .finish(finish), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_start_ts(rec_start_ts), .rec_latency(rec_latency),
    .rec_interval(rec_interval), .txn_count(txn_count), .busy_cycles(busy_cycles),
    .stall_cycles(stall_cycles), .overflow(overflow), .inflight_err(inflight_err),
    .done_flush(done_flush)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic s, input logic d, input logic c);
    ap_start = s;
    ap_done = d;
    ap_continue = c;
    tick();
    ap_start = 1'b0;
    ap_done = 1'b0;
    ap_continue = 1'b1;
  endtask
  // Leaves the DUT out of reset just after a clock edge, so the next edge samples ts=0
  task automatic do_reset();
    reset = 1'b1;
    finish = 1'b0;
    ap_start = 1'b0;
    ap_done = 1'b0;
    ap_continue = 1'b1;
    rec_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input int idx, input int sts, input int lat, input int intv);
    chk({tag, ".valid"}, rec_valid, 1);
    chk({tag, ".idx"}, rec_idx, idx);
    chk({tag, ".start_ts"}, rec_start_ts, sts);
    chk({tag, ".latency"}, rec_latency, lat);
    chk({tag, ".interval"}, rec_interval, intv);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst.valid", rec_valid, 0);
    chk("rst.txn", txn_count, 0);
    chk("rst.busy", busy_cycles, 0);
    chk("rst.stall", stall_cycles, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.err", inflight_err, 0);
    chk("rst.flush", done_flush, 0);
    chk("rst.idx", rec_idx, 0);
    // single transaction: accept at ts=5, complete at ts=17
    repeat (5) tick();
    drive(1, 0, 1);
    repeat (11) tick();
    drive(0, 1, 1);
    chk("t1.txn", txn_count, 1);
    chk("t1.busy", busy_cycles, 13);
    pop_chk("t1.rec", 0, 5, 12, 0);
    chk("t1.err", inflight_err, 0);
    chk("t1.empty", rec_valid, 0);
    // pipelined overlap
    do_reset();
    for (int t = 0; t < 26; t++) begin
      ap_start = (t == 10 || t == 12 || t == 14);
      ap_done  = (t == 20 || t == 22 || t == 24);
      tick();
    end
    ap_start = 1'b0;
    ap_done = 1'b0;
    chk("t2.txn", txn_count, 3);
    chk("t2.err", inflight_err, 0);
    pop_chk("t2.r0", 0, 10, 10, 0);
    pop_chk("t2.r1", 1, 12, 10, 2);
    pop_chk("t2.r2", 2, 14, 10, 2);
    // backpressure: ten completions into an eight-deep record FIFO
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 1);
      drive(0, 1, 1);
    end
    chk("t3.ovf", overflow, 1);
    chk("t3.txn", txn_count, 10);
    chk("t3.err", inflight_err, 0);
    for (int k = 0; k < 8; k++) pop_chk("t3.rec", k, 2 * k, 1, k == 0 ? 0 : 2);
    chk("t3.drained", rec_valid, 0);
    // done on an empty queue
    do_reset();
    drive(0, 1, 1);
    chk("t4a.err", inflight_err, 1);
    chk("t4a.valid", rec_valid, 0);
    chk("t4a.txn", txn_count, 0);
    // start queue overflow
    do_reset();
    repeat (4) drive(1, 0, 1);
    chk("t4b.err4", inflight_err, 0);
    drive(1, 0, 1);
    chk("t4b.err5", inflight_err, 1);
    // same-cycle accept and complete on an empty queue
    do_reset();
    repeat (3) tick();
    drive(1, 1, 1);
    chk("t4c.err", inflight_err, 0);
    pop_chk("t4c.rec", 0, 3, 0, 0);
    // stall counting then finish/drain
    do_reset();
    ap_done = 1'b1;
    ap_continue = 1'b0;
    repeat (3) tick();
    ap_done = 1'b0;
    ap_continue = 1'b1;
    chk("t5.stall", stall_cycles, 3);
    repeat (2) begin
      drive(1, 0, 1);
      drive(0, 1, 1);
    end
    chk("t5.pending", rec_valid, 1);
    finish = 1'b1;
    rec_ready = 1'b1;
    tick();
    finish = 1'b0;
    chk("t5.flush_early", done_flush, 0);
    tick();
    tick();
    chk("t5.flush", done_flush, 1);
    chk("t5.drained", rec_valid, 0);
    chk("t5.busy", busy_cycles, 4);
    repeat (2) begin
      drive(1, 0, 1);
      drive(0, 1, 1);
    end
    drive(0, 1, 1);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    rec_ready = 1'b0;
    chk("t5.frozen_txn", txn_count, 2);
    chk("t5.frozen_busy", busy_cycles, 4);
    chk("t5.frozen_err", inflight_err, 0);
    chk("t5.frozen_valid", rec_valid, 0);
    chk("t5.flush_hold", done_flush, 1);
    // asynchronous reset mid-transaction
    do_reset();
    repeat (3) begin
      drive(1, 0, 1);
      drive(0, 1, 1);
    end
    drive(1, 0, 1);
    drive(1, 0, 1);
    chk("t6.pre_txn", txn_count, 3);
    chk("t6.pre_lat", rec_latency, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("t6.valid", rec_valid, 0);
    chk("t6.txn", txn_count, 0);
    chk("t6.busy", busy_cycles, 0);
    chk("t6.lat", rec_latency, 0);
    chk("t6.err", inflight_err, 0);
    chk("t6.flush", done_flush, 0);
    #2;
    reset = 1'b0;
    drive(1, 1, 1);
    pop_chk("t6.run", 0, 0, 0, 0);
    chk("t6.post_err", inflight_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ap_handshake_profiler.md
Name: ap_handshake_profiler

Overview:
- Synthesizable cycle profiler for one HLS `ap_ctrl_hs` sub-module, such as a `deQAM` pipeline loop.
- Sits directly downstream of that module's `ap_start` / `ap_ready` / `ap_done` / `ap_continue` signals.
- Pairs each accepted start with its completion and emits one timestamped record per transaction to a record sink (CSV dumper or AXI bridge).
- Also keeps aggregate busy/stall counters for post-run dump.

Parameters:
- CNT_W, 32, width of timestamp and all counters.
- INFL_DEPTH, 4, maximum outstanding (accepted, not completed) transactions.
- REC_DEPTH, 8, record FIFO depth.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- finish  in  1  end-of-simulation/run request
- ap_start  in  1  monitored module start
- ap_ready  in  1  monitored module ready
- ap_done  in  1  monitored module done
- ap_continue  in  1  monitored module continue
- rec_valid  out  1  record available
- rec_ready  in  1  sink accepts record
- rec_idx  out  CNT_W  transaction index, 0-based
- rec_start_ts  out  CNT_W  cycle of start acceptance
- rec_latency  out  CNT_W  done_ts minus start_ts
- rec_interval  out  CNT_W  start_ts minus previous start_ts (0 for first)
- txn_count  out  CNT_W  completed transactions
- busy_cycles  out  CNT_W  cycles with outstanding work or ap_start high
- stall_cycles  out  CNT_W  cycles with ap_done=1 and ap_continue=0
- overflow  out  1  sticky: record dropped because FIFO full
- inflight_err  out  1  sticky: start queue overflow, or done with nothing outstanding
- done_flush  out  1  drain complete after finish

Behaviour:
- Reset (asynchronous, active-high): every output 0, all queues empty, FSM in RUN.
- Timestamp `ts`:
  - Resets to 0, increments every cycle, saturates at 2^CNT_W-1.
  - All other counters also saturate.
- Accept event: `ap_start && ap_ready` in RUN.
  - Pushes {ts, interval} into the start queue (depth INFL_DEPTH).
  - `last_accept_ts` updates to ts.
  - Queue full: set inflight_err, drop the entry.
- Complete event: `ap_done && ap_continue` in RUN.
  - Pops the oldest start entry and forms the record: latency = ts - start_ts.
  - txn_count increments.
  - Record pushed to the record FIFO. FIFO full: overflow=1 and the record is dropped; txn_count and rec_idx numbering still advance.
- Simultaneous accept and complete:
  - Queue empty: bypass; the record uses the current accept, latency=0.
  - Queue non-empty: pop and push in the same cycle; occupancy unchanged, no overflow even when full.
- Complete with empty queue and no same-cycle accept: inflight_err=1, no record, txn_count unchanged.
- Counters:
  - busy_cycles increments when queue non-empty or ap_start=1.
  - stall_cycles increments when ap_done && !ap_continue.
- Record output:
  - First-word-fall-through, registered outputs.
  - rec_* fields are stable while rec_valid && !rec_ready.
  - Pop on rec_valid && rec_ready.
  - A record pushed in cycle N is visible with rec_valid no earlier than N+1.
- FSM:
  - RUN: normal operation. `finish=1` moves to DRAIN.
  - DRAIN: ap_* inputs ignored, counters frozen, records still drained. Record FIFO empty and no pending output moves to DONE.
  - DONE: done_flush=1, held until reset. finish is ignored after RUN.
- Reset mid-transaction: all state cleared, no partial record emitted.

Decomposition:
- Package `ap_prof_pkg`:
  - `prof_rec_t` struct {idx, start_ts, latency, interval}.
  - `prof_state_e` {RUN, DRAIN, DONE}.
  - Saturating-increment function.
- Sub-module `ap_prof_fifo`:
  - Parameterized sync FWFT FIFO (WIDTH, DEPTH).
  - Simultaneous push/pop when full is legal.
  - Instantiated twice: start queue and record FIFO.

Test Plan:
1. Single transaction: start accepted at ts=5, done+continue at ts=17, rec_ready=1 -> one record {idx=0, start_ts=5, latency=12, interval=0}; txn_count=1.
2. Pipelined overlap: accepts at ts=10,12,14 and dones at 20,22,24 -> latencies 10,10,10; intervals 0,2,2; inflight_err=0.
3. Backpressure: rec_ready=0 with 10 completions, REC_DEPTH=8 -> 8 records retained, overflow=1, txn_count=10; rec_ready=1 then yields idx 0..7 in order.
4. Boundaries:
   - done with empty queue -> inflight_err=1, no record.
   - 5 accepts with no done, INFL_DEPTH=4 -> inflight_err=1.
   - Same-cycle accept+done on empty queue -> latency=0.
5. Stall and finish:
   - ap_done=1, ap_continue=0 for 3 cycles -> stall_cycles=3.
   - finish with 2 records pending, rec_ready=1 -> DONE, done_flush=1 within 3 cycles.
   - Later ap_* activity -> no change.
6. Reset asynchronously mid-transaction with 2 outstanding and 3 records queued -> all outputs 0 immediately, rec_valid=0, FSM in RUN.
